// File: rtl/stream_source_if.sv
// Source-to-sink handshake bundle: LFSR word stream out, result stream back.
// The master modport is the stream_source side; the slave modport is the sink side.
interface stream_source_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int RESULT_WIDTH = 8
);
  logic [DATA_WIDTH-1:0]   data_out;
  logic                    data_out_valid;
  logic                    ready;
  logic [RESULT_WIDTH-1:0] result_in;
  logic                    result_in_valid;

  modport master (
    output data_out,
    output data_out_valid,
    input  ready,
    input  result_in,
    input  result_in_valid
  );

  modport slave (
    input  data_out,
    input  data_out_valid,
    output ready,
    output result_in,
    output result_in_valid
  );
endinterface

// File: rtl/stream_source.sv
// Stream source: sends num_items LFSR words with forced hold-off gaps, then drains returned results.
// Optional feature macro: STREAM_SOURCE_CHECKSUM_EN enables the rotate-xor result checksum.
//
// state | meaning
// IDLE  | after reset, waiting for start
// SEND  | presenting a word, transfer when ready
// HOLD  | HOLDOFF forced idle cycles after a transfer
// DRAIN | all words sent, waiting for remaining results or timeout
// DONE  | run finished (err tells whether it failed)
module stream_source #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          RESULT_WIDTH = 8,
  parameter int          COUNT_WIDTH  = 32,
  parameter int          HOLDOFF      = 2,
  parameter int          TIMEOUT      = 1024,
  parameter logic [31:0] SEED         = 32'h0000_0001
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] num_items,
  stream_source_if.master        bus,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [COUNT_WIDTH-1:0] sent_count,
  output logic [COUNT_WIDTH-1:0] recv_count,
  output logic [31:0]            checksum
);

  if (DATA_WIDTH > 32 || RESULT_WIDTH > 32 || HOLDOFF < 1 || TIMEOUT < 1 || SEED == 32'h0)
  begin : g_param_check
    $error("stream_source: unsupported parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_HOLD,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF - 1);
  localparam logic [TMO_W-1:0]  TMO_LOAD  = TMO_W'(TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic [31:0]            lfsr_q, lfsr_d;
  logic [COUNT_WIDTH-1:0] num_q, num_d;
  logic [COUNT_WIDTH-1:0] sent_q, sent_d;
  logic [COUNT_WIDTH-1:0] recv_q, recv_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   active;
  logic                   xfer;
  logic                   accept_start;
  logic                   result_cnt;
  logic                   overrun;
  logic [COUNT_WIDTH-1:0] sent_inc;
  logic [COUNT_WIDTH-1:0] recv_inc;

  assign active       = (state_q == S_SEND) || (state_q == S_HOLD) || (state_q == S_DRAIN);
  assign xfer         = (state_q == S_SEND) && bus.ready;
  assign accept_start = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign overrun      = active && bus.result_in_valid && (recv_q == num_q);
  assign result_cnt   = active && bus.result_in_valid && (recv_q != num_q);
  assign sent_inc     = sent_q + COUNT_WIDTH'(1);
  assign recv_inc     = recv_q + COUNT_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    num_d   = num_q;
    sent_d  = sent_q;
    recv_d  = recv_q;
    hold_d  = hold_q;
    tmo_d   = tmo_q;
    err_d   = err_q;

    // Results are counted in any busy state, not only DRAIN.
    if (result_cnt) recv_d = recv_inc;
    if (overrun)    err_d  = 1'b1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_start) begin
          num_d   = num_items;
          sent_d  = '0;
          recv_d  = '0;
          err_d   = 1'b0;
          state_d = (num_items == '0) ? S_DONE : S_SEND;
        end
      end
      S_SEND: begin
        if (xfer) begin
          lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_MASK : 32'h0);
          sent_d = sent_inc;
          if (sent_inc == num_q) begin
            state_d = S_DRAIN;
            tmo_d   = TMO_LOAD;
          end else begin
            state_d = S_HOLD;
            hold_d  = HOLD_LOAD;
          end
        end
      end
      S_HOLD: begin
        if (hold_q == '0) state_d = S_SEND;
        else              hold_d  = hold_q - HOLD_W'(1);
      end
      S_DRAIN: begin
        if (recv_d == num_q) begin
          state_d = S_DONE;
        end else if (result_cnt) begin
          tmo_d = TMO_LOAD;
        end else if (tmo_q == '0) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_SEND) || (state_d == S_HOLD) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      num_q   <= '0;
      sent_q  <= '0;
      recv_q  <= '0;
      hold_q  <= '0;
      tmo_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      num_q   <= num_d;
      sent_q  <= sent_d;
      recv_q  <= recv_d;
      hold_q  <= hold_d;
      tmo_q   <= tmo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

`ifdef STREAM_SOURCE_CHECKSUM_EN
  logic [31:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if (accept_start)    cksum_d = '0;
    else if (result_cnt) cksum_d = {cksum_q[30:0], cksum_q[31]} ^ 32'(bus.result_in[RESULT_WIDTH-1:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cksum_q <= '0;
    else     cksum_q <= cksum_d;
  end

  assign checksum = cksum_q;
`else
  assign checksum = '0;
`endif

  assign bus.data_out       = DATA_WIDTH'(lfsr_q);
  assign bus.data_out_valid = xfer;
  assign busy               = busy_q;
  assign done               = done_q;
  assign err                = err_q;
  assign sent_count         = sent_q;
  assign recv_count         = recv_q;

endmodule

// File: doc/stream_source.md
STREAM_SOURCE -- requirements
Module: stream_source

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the transmitted word.
REQ-002 SHALL have parameter RESULT_WIDTH, default 8, width of the returned result.
REQ-003 SHALL have parameter COUNT_WIDTH, default 32, width of the item and result counters.
REQ-004 SHALL have parameter HOLDOFF, default 2 (min 1), idle cycles forced after each transfer.
REQ-005 SHALL have parameter TIMEOUT, default 1024, maximum DRAIN cycles without a result.
REQ-006 SHALL have parameter SEED, default 32'h0000_0001 (nonzero), LFSR reset value.
REQ-007 clk  in  1  clock, rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 start  in  1  begin a run; sampled only in IDLE or DONE.
REQ-010 num_items  in  COUNT_WIDTH  items to send; sampled on the accepted start.
REQ-011 ready  in  1  sink may accept a word this cycle.
REQ-012 data_out  out  DATA_WIDTH  word presented to the sink.
REQ-013 data_out_valid  out  1  transfer strobe.
REQ-014 result_in  in  RESULT_WIDTH  returned result from the sink pipeline.
REQ-015 result_in_valid  in  1  result_in is valid this cycle.
REQ-016 busy, done, err  out  1 each  run active / run complete / run failed.
REQ-017 sent_count, recv_count  out  COUNT_WIDTH each  transfers issued / results received.
REQ-018 checksum  out  32  running result checksum.

Function
REQ-019 States SHALL be IDLE, SEND, HOLD, DRAIN, DONE.
REQ-020 On start in IDLE or DONE, the block SHALL latch num_items, clear both counters, checksum and err, and go to SEND (or to DONE when num_items==0).
REQ-021 A start arriving in SEND, HOLD or DRAIN SHALL be ignored.
REQ-022 data_out_valid SHALL be combinational: (state==SEND) && ready; a transfer occurs in every cycle where it is 1.
REQ-023 data_out SHALL be driven from the LFSR register and stay stable while no transfer occurs.
REQ-024 LFSR SHALL be 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003); it advances one step per transfer; data_out SHALL be the low DATA_WIDTH bits.
REQ-025 On a transfer, sent_count SHALL increment; the next state SHALL be DRAIN if the incremented count equals num_items, otherwise HOLD.
REQ-026 HOLD SHALL last exactly HOLDOFF cycles and then return to SEND, so that valid never pulses in consecutive cycles.
REQ-027 While busy, each result_in_valid SHALL increment recv_count, independent of state and including while in SEND or HOLD.
REQ-028 In DRAIN, the block SHALL go to DONE when recv_count reaches num_items, including the cycle in which the final result arrives.
REQ-029 In DRAIN, a cycle counter SHALL reset on each result; when it reaches TIMEOUT, the block SHALL set err and go to DONE.
REQ-030 A result_in_valid while recv_count==num_items and busy SHALL set err (overrun) and SHALL NOT increment recv_count.
REQ-031 result_in_valid in IDLE or DONE SHALL be ignored.
REQ-032 busy SHALL be 1 in SEND, HOLD and DRAIN; done SHALL be 1 only in DONE; err SHALL hold until the next accepted start.
REQ-033 Counters SHALL wrap modulo 2^COUNT_WIDTH.

Reset
REQ-034 While rst is high: state=IDLE, LFSR=SEED, sent_count=0, recv_count=0, checksum=0, busy=0, done=0, err=0, data_out_valid=0.
REQ-035 rst asserted mid-run SHALL abort immediately with no further transfers; the LFSR SHALL restart from SEED.

Configuration
REQ-036 With STREAM_SOURCE_CHECKSUM_EN defined, each counted result SHALL update checksum = {checksum[30:0],checksum[31]} ^ zero-extended result_in.
REQ-037 Without STREAM_SOURCE_CHECKSUM_EN, checksum SHALL be constant 0 and its logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-038 ready held 1, num_items=3, HOLDOFF=2 -> valid SHALL pulse in cycles 1, 4 and 7 after start, with data 32'h0000_0001, then the two subsequent LFSR values; sent_count=3.
REQ-039 num_items=0 -> DONE one cycle after start, with no valid pulse and err=0.
REQ-040 ready held 0 for 10 cycles in SEND, then 1 -> no transfer during those cycles, data_out stable, exactly one transfer when ready rises.
REQ-041 num_items=2 with two results 8'h05 and 8'h03 (CHECKSUM_EN) -> done=1, recv_count=2, checksum=32'h0000_0009.
REQ-042 num_items=2 with only one result, TIMEOUT=16 -> err=1, done=1 after 16 idle DRAIN cycles.
REQ-043 rst pulsed while in HOLD -> all outputs at their reset values next cycle; a subsequent start resends SEED first.
